// File: rtl/multadd_arbiter_if.sv
// Bundle of requester handshake, response, and multadd-side signals for multadd_arbiter.
interface multadd_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ*8-1:0] req_c;
  logic [NREQ*8-1:0] req_d;
  logic [NREQ-1:0]   rsp_valid;
  logic [16:0]       rsp_data;
  logic [7:0]        ma_a;
  logic [7:0]        ma_b;
  logic [7:0]        ma_c;
  logic [7:0]        ma_d;
  logic              ma_pipeline;
  logic [16:0]       ma_prodsum;
  logic              ma_prodout;
  logic              err_orphan;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_c, req_d, ma_prodsum, ma_prodout,
    output req_ready, rsp_valid, rsp_data, ma_a, ma_b, ma_c, ma_d, ma_pipeline, err_orphan
  );

  // Environment side (requesters plus the multadd)
  modport master (
    output req_valid, req_a, req_b, req_c, req_d, ma_prodsum, ma_prodout,
    input  req_ready, rsp_valid, rsp_data, ma_a, ma_b, ma_c, ma_d, ma_pipeline, err_orphan
  );
endinterface

// File: rtl/multadd_arbiter.sv
// Round-robin front end sharing one two-stage multadd among NREQ requesters.
// An in-order tag FIFO routes each result back to the requester that issued it.
module multadd_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic             clk,
  input  logic             rst,
  multadd_arbiter_if.slave bus
);
  localparam int FDEPTH = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GAP  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TAGW-1:0]   r_last_grant;
  logic [1:0]        r_guard;
  logic [TAGW-1:0]   r_fifo [FDEPTH];
  logic [1:0]        r_wptr;
  logic [1:0]        r_rptr;
  logic [2:0]        r_count;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [16:0]       r_rsp_data;
  logic [7:0]        r_ma_a;
  logic [7:0]        r_ma_b;
  logic [7:0]        r_ma_c;
  logic [7:0]        r_ma_d;
  logic              r_ma_pipeline;
  logic              r_err_orphan;

  logic              w_guard_active;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_found;
  logic              w_xfer;
  logic              w_pop;
  logic [TAGW-1:0]   w_grant_idx;
  logic [TAGW:0]     w_cand;
  logic [NREQ-1:0]   w_ready;
  logic [TAGW+2:0]   w_base;

  function automatic logic [NREQ-1:0] f_onehot(input logic [TAGW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  assign w_guard_active = (r_guard != 2'd0);
  assign w_fifo_full    = (r_count == 3'd4);
  assign w_fifo_empty   = (r_count == 3'd0);
  assign w_xfer         = |(bus.req_valid & w_ready);
  assign w_pop          = bus.ma_prodout & ~w_fifo_empty;
  assign w_base         = {w_grant_idx, 3'b000};

  // Round-robin search for a valid requester, starting one past the last grant
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = {TAGW{1'b0}};
    w_cand      = {(TAGW+1){1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = {1'b0, r_last_grant} + (TAGW+1)'(k);
      if (w_cand >= (TAGW+1)'(NREQ)) begin
        w_cand = w_cand - (TAGW+1)'(NREQ);
      end else begin
        w_cand = w_cand;
      end
      if (!w_found && bus.req_valid[w_cand[TAGW-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand[TAGW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Issue FSM next state and grant: one grant, then a forced idle cycle
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = {NREQ{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (w_found && !w_fifo_full && !w_guard_active) begin
          w_ready     = f_onehot(w_grant_idx);
          w_state_nxt = S_GAP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Post-reset guard: hide stale multadd pipeline contents for three cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_guard <= 2'd3;
    end else if (w_guard_active) begin
      r_guard <= r_guard - 2'd1;
    end else begin
      r_guard <= r_guard;
    end
  end

  // Issue registers: capture the granted operand set and strobe the multadd
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ma_a        <= 8'd0;
      r_ma_b        <= 8'd0;
      r_ma_c        <= 8'd0;
      r_ma_d        <= 8'd0;
      r_ma_pipeline <= 1'b0;
      r_last_grant  <= TAGW'(NREQ - 1);
    end else if (w_xfer) begin
      r_ma_a        <= bus.req_a[w_base +: 8];
      r_ma_b        <= bus.req_b[w_base +: 8];
      r_ma_c        <= bus.req_c[w_base +: 8];
      r_ma_d        <= bus.req_d[w_base +: 8];
      r_ma_pipeline <= 1'b1;
      r_last_grant  <= w_grant_idx;
    end else begin
      r_ma_pipeline <= 1'b0;
    end
  end

  // In-order ownership FIFO: push on issue, pop on each returned result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FDEPTH; i++) begin
        r_fifo[i] <= {TAGW{1'b0}};
      end
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_xfer) begin
        r_fifo[r_wptr] <= w_grant_idx;
        r_wptr         <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      case ({w_xfer, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Return path: route result to the head-of-FIFO owner, flag orphan strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid  <= {NREQ{1'b0}};
      r_rsp_data   <= 17'd0;
      r_err_orphan <= 1'b0;
    end else if (w_pop) begin
      r_rsp_valid <= f_onehot(r_fifo[r_rptr]);
      r_rsp_data  <= bus.ma_prodsum;
    end else begin
      r_rsp_valid <= {NREQ{1'b0}};
      if (bus.ma_prodout && !w_guard_active) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.ma_a        = r_ma_a;
  assign bus.ma_b        = r_ma_b;
  assign bus.ma_c        = r_ma_c;
  assign bus.ma_d        = r_ma_d;
  assign bus.ma_pipeline = r_ma_pipeline;
  assign bus.err_orphan  = r_err_orphan;
endmodule

// File: doc/multadd_arbiter.md
# multadd_arbiter

Round-robin scheduler that shares one `multadd` instance (two-stage 8x8+8x8 multiply-add, 17-bit result) among NREQ requesters. It accepts operand sets over per-requester valid/ready handshakes and drives the multadd `pipeline` strobe and operands. It tracks in-flight ownership in an in-order tag FIFO and returns each 17-bit result to the requester that issued it. It sits directly in front of `multadd`, shares its `clk`/`rst`, and enforces the multadd's minimum issue spacing.

## Interface
- NREQ, 4, number of requesters (2..8)
- TAGW, 2, tag width = ceil(log2(NREQ))
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset; also drives the multadd `rst`
- req_valid  in  NREQ  per-requester request; held with operands until accepted
- req_a, req_b, req_c, req_d  in  NREQ*8 each  packed operands; requester i uses bits [8i+7:8i]
- req_ready  out  NREQ  one-hot accept, combinational; transfer when req_valid[i] & req_ready[i] at a rising edge
- rsp_valid  out  NREQ  one-hot, registered, single-cycle result strobe
- rsp_data  out  17  result a*b + c*d, valid while any rsp_valid bit is high
- ma_a, ma_b, ma_c, ma_d  out  8 each  registered operands to multadd
- ma_pipeline  out  1  registered issue strobe to multadd
- ma_prodsum  in  17  multadd result
- ma_prodout  in  1  multadd result strobe
- err_orphan  out  1  sticky; result strobe arrived with no op in flight

## Operation
- Issue FSM has two states, IDLE and GAP.
  - IDLE: a grant is allowed when any req_valid is high and the tag FIFO is not full. The granted index gets req_ready. Go to GAP.
  - GAP: req_ready stays 0 for exactly one cycle, then return to IDLE.
- Consequence: ma_pipeline is never high in two consecutive cycles. This is mandatory; back-to-back strobes corrupt the multadd result.
- Round-robin arbitration:
  - Search starts at (last_grant+1) mod NREQ.
  - last_grant resets to NREQ-1, so requester 0 has first priority.
  - Only requesters with req_valid=1 are eligible.
- On transfer:
  - ma_a..ma_d <= selected operands; ma_pipeline <= 1 for one cycle.
  - The granted index is pushed into the tag FIFO (depth 4, TAGW bits).
  - last_grant <= granted index.
- While no transfer occurs, ma_pipeline <= 0 and ma_a..ma_d hold their last value.
- Return path on ma_prodout=1:
  - If the tag FIFO is non-empty: pop the head tag, rsp_data <= ma_prodsum, rsp_valid <= onehot(tag).
  - If the FIFO is empty and the guard counter has expired: err_orphan <= 1 (sticky until rst); no rsp_valid.
  - If the guard is active: ignore the strobe.
- Guard counter:
  - Counts 3 cycles after rst deasserts.
  - Covers multadd internal pipeline state that is not reset.
  - No grants are made while the guard is active.
- Push and pop in the same cycle are both performed; FIFO occupancy is unchanged.
- FIFO full (4 entries) blocks grants. This cannot occur with a correct multadd, since at most 2 ops are in flight.
- rsp_data is 17 bits; maximum value is 2*255*255 = 130050. No truncation is allowed.

## Timing
- Reset values, applied asynchronously when rst=1:
  - req_ready=0, rsp_valid=0, rsp_data=0
  - ma_a..ma_d=0, ma_pipeline=0
  - err_orphan=0
  - FSM=IDLE, FIFO empty, last_grant=NREQ-1, guard=3
- After rst deasserts, the first possible grant is in the 4th cycle.
- Accept at edge T0 -> ma_pipeline high in cycle T0+ -> multadd samples at T1 -> ma_prodout and ma_prodsum valid after T3 -> rsp_valid/rsp_data registered at T4.
- Fixed latency is 4 edges from accept to rsp_valid; rsp_valid is high for exactly one cycle.
- Maximum throughput is one op per 2 cycles. Results return in issue order.
- Reset mid-operation:
  - All in-flight ops are discarded and no rsp_valid is produced for them.
  - The FIFO is cleared; requesters must re-issue.
- A requester dropping req_valid before transfer is legal; no grant goes to it that cycle.

## Test plan
- Single op: requester 1 sends a=3, b=4, c=5, d=6 -> req_ready[1] at T0, rsp_valid=4'b0010 at T4, rsp_data=42.
- Max operands: a=b=c=d=255 -> rsp_data=130050 with bit 16 set.
- All 4 requesters hold req_valid from reset:
  - Grants go 0,1,2,3,0 at 2-cycle spacing.
  - ma_pipeline is never high in consecutive cycles.
  - Each rsp returns to the correct owner with the correct product.
- Requester 2 holds valid continuously while requester 0 toggles -> requester 2 is never starved; grants alternate whenever both are valid.
- Assert rst for 1 cycle while 2 ops are in flight -> no rsp_valid for them; first new grant 4 cycles after release; err_orphan stays 0.
- Force ma_prodout=1 with the FIFO empty after the guard expires -> err_orphan=1, no rsp_valid; it stays 1 until rst.
